// File: rtl/plic_claim_master_pkg.sv
// Shared types and constants for the PLIC claim/complete bus master.
package plic_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLAIM    = 2'd1,
        DISPATCH = 2'd2,
        COMPLETE = 2'd3
    } plic_state_e;

    localparam logic [31:0] CLAIM_OFFSET_CTX0 = 32'h0020_0004;
    localparam int          PLIC_ID_W         = 32;
    localparam logic [3:0]  FULL_MASK         = 4'b1111;

    // A claimed ID is real only in 1..max_src; 0 means "nothing pending".
    function automatic logic id_is_valid(input logic [PLIC_ID_W-1:0] id,
                                         input int unsigned max_src);
        return (id != '0) && (id <= PLIC_ID_W'(max_src));
    endfunction

endpackage

// File: rtl/plic_claim_master_if.sv
// Bus-master port bundle between the claim master and the memory arbiter.
interface plic_claim_master_if;
    logic        memRequest;
    logic        memReady;
    logic [31:0] memAddress;
    logic        memWrite;
    logic [31:0] memWriteData;
    logic [3:0]  byteMask;
    logic [31:0] memReadData;

    modport master (
        output memRequest, memAddress, memWrite, memWriteData, byteMask,
        input  memReady, memReadData
    );

    modport slave (
        input  memRequest, memAddress, memWrite, memWriteData, byteMask,
        output memReady, memReadData
    );
endinterface

// File: rtl/plic_claim_master.sv
// Turns the PLIC EIP level into a claim read / dispatch / complete write sequence.
// Optional claim statistics counters are built when PLIC_CLAIM_STATS_EN is defined.
module plic_claim_master
    import plic_pkg::*;
#(
    parameter logic [31:0] PLIC_BASE    = 32'h0000_0000,
    parameter logic [31:0] CLAIM_OFFSET = CLAIM_OFFSET_CTX0,
    parameter int unsigned MAX_SOURCE   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 EIP,
    input  logic                 globalEnable,
    input  logic                 irqDone,
    output logic                 irqValid,
    output logic [PLIC_ID_W-1:0] irqId,
    output logic                 busy,
`ifdef PLIC_CLAIM_STATS_EN
    output logic [15:0]          claimCount,
    output logic [15:0]          spuriousCount,
`endif
    plic_claim_master_if.master  bus
);

    localparam logic [31:0] CLAIM_ADDR = PLIC_BASE + CLAIM_OFFSET;

    plic_state_e          state_q, state_d;
    logic [PLIC_ID_W-1:0] id_q, id_d;
    logic                 claim_grant;
    logic                 claim_ok;

    assign claim_grant = (state_q == CLAIM) && bus.memReady;
    assign claim_ok    = id_is_valid(bus.memReadData, MAX_SOURCE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (EIP && globalEnable) state_d = CLAIM;
            end
            CLAIM: begin
                // EIP may drop here; the read is already committed to the bus.
                if (bus.memReady) begin
                    id_d    = bus.memReadData;
                    state_d = claim_ok ? DISPATCH : IDLE;
                end
            end
            DISPATCH: begin
                if (irqDone) state_d = COMPLETE;
            end
            COMPLETE: begin
                if (bus.memReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, never an input.
    always_comb begin
        bus.memRequest   = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memAddress   = '0;
        bus.memWriteData = '0;
        bus.byteMask     = '0;
        irqValid         = 1'b0;
        irqId            = '0;
        busy             = (state_q != IDLE);
        unique case (state_q)
            CLAIM: begin
                bus.memRequest = 1'b1;
                bus.memAddress = CLAIM_ADDR;
                bus.byteMask   = FULL_MASK;
            end
            DISPATCH: begin
                irqValid = 1'b1;
                irqId    = id_q;
            end
            COMPLETE: begin
                bus.memRequest   = 1'b1;
                bus.memWrite     = 1'b1;
                bus.memAddress   = CLAIM_ADDR;
                bus.memWriteData = id_q;
                bus.byteMask     = FULL_MASK;
            end
            default: ;
        endcase
    end

`ifdef PLIC_CLAIM_STATS_EN
    logic [15:0] claim_count_q, spurious_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            claim_count_q    <= '0;
            spurious_count_q <= '0;
        end else if (claim_grant) begin
            claim_count_q <= claim_count_q + 16'd1;
            if (!claim_ok) spurious_count_q <= spurious_count_q + 16'd1;
        end
    end

    assign claimCount    = claim_count_q;
    assign spuriousCount = spurious_count_q;
`else
    logic unused_grant;
    assign unused_grant = claim_grant;
`endif

endmodule

// File: tb/tb_plic_claim_master.sv
// Directed table-driven bench for plic_claim_master plus hand-written corner sequences.
module tb_plic_claim_master;
    import plic_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        EIP;
    logic        globalEnable;
    logic        irqDone;
    logic        irqValid;
    logic [31:0] irqId;
    logic        busy;
`ifdef PLIC_CLAIM_STATS_EN
    logic [15:0] claimCount;
    logic [15:0] spuriousCount;
`endif

    plic_claim_master_if bus ();

    plic_claim_master #(
        .PLIC_BASE   (32'h0000_0000),
        .CLAIM_OFFSET(32'h0020_0004),
        .MAX_SOURCE  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .EIP         (EIP),
        .globalEnable(globalEnable),
        .irqDone     (irqDone),
        .irqValid    (irqValid),
        .irqId       (irqId),
        .busy        (busy),
`ifdef PLIC_CLAIM_STATS_EN
        .claimCount   (claimCount),
        .spuriousCount(spuriousCount),
`endif
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, eip, ge, rdy, done;
        logic [31:0] rd;
        logic        req, wr;
        logic [31:0] wdata;
        logic        valid;
        logic [31:0] id;
        logic        bsy;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, eip, ge, rdy, done,
                                input logic [31:0] rd,
                                input logic req, wr,
                                input logic [31:0] wdata,
                                input logic valid,
                                input logic [31:0] id,
                                input logic bsy);
        vec_t v;
        v.rst = rst; v.eip = eip; v.ge = ge; v.rdy = rdy; v.done = done; v.rd = rd;
        v.req = req; v.wr = wr; v.wdata = wdata; v.valid = valid; v.id = id; v.bsy = bsy;
        return v;
    endfunction

    task automatic check_all(input int idx, input logic req, wr,
                             input logic [31:0] wdata, input logic valid,
                             input logic [31:0] id, input logic bsy);
        chk("memRequest",   idx, {31'd0, bus.memRequest}, {31'd0, req});
        chk("memWrite",     idx, {31'd0, bus.memWrite},   {31'd0, wr});
        chk("memAddress",   idx, bus.memAddress, req ? 32'h0020_0004 : 32'h0);
        chk("memWriteData", idx, bus.memWriteData, wdata);
        chk("byteMask",     idx, {28'd0, bus.byteMask}, req ? 32'hF : 32'h0);
        chk("irqValid",     idx, {31'd0, irqValid}, {31'd0, valid});
        chk("irqId",        idx, irqId, id);
        chk("busy",         idx, {31'd0, busy}, {31'd0, bsy});
    endtask

    initial begin
        int writes;
        //             rst eip ge rdy done rd    | req wr wdata valid id bsy
        vecs[0]  = mk(1, 1, 0, 1, 0, 32'h0,   0, 0, 32'h0, 0, 32'h0, 0);
        vecs[1]  = mk(1, 1, 1, 1, 0, 32'h2,   0, 0, 32'h0, 0, 32'h0, 0);
        vecs[2]  = mk(0, 1, 1, 1, 0, 32'h2,   1, 0, 32'h0, 0, 32'h0, 1);
        vecs[3]  = mk(0, 1, 1, 1, 0, 32'h2,   0, 0, 32'h0, 1, 32'h2, 1);
        vecs[4]  = mk(0, 0, 1, 1, 1, 32'h2,   1, 1, 32'h2, 0, 32'h0, 1);
        vecs[5]  = mk(0, 0, 1, 1, 0, 32'h2,   0, 0, 32'h0, 0, 32'h0, 0);
        // claim stalled three cycles; read data during stall is ignored
        vecs[6]  = mk(0, 1, 1, 0, 0, 32'h3,   1, 0, 32'h0, 0, 32'h0, 1);
        vecs[7]  = mk(0, 0, 1, 0, 0, 32'h3,   1, 0, 32'h0, 0, 32'h0, 1);
        vecs[8]  = mk(0, 0, 1, 0, 0, 32'h3,   1, 0, 32'h0, 0, 32'h0, 1);
        vecs[9]  = mk(0, 0, 1, 0, 0, 32'h3,   1, 0, 32'h0, 0, 32'h0, 1);
        vecs[10] = mk(0, 0, 1, 1, 0, 32'h1,   0, 0, 32'h0, 1, 32'h1, 1);
        vecs[11] = mk(0, 0, 0, 1, 0, 32'h3,   0, 0, 32'h0, 1, 32'h1, 1);
        vecs[12] = mk(0, 0, 0, 0, 1, 32'h3,   1, 1, 32'h1, 0, 32'h0, 1);
        // complete stalled three cycles
        vecs[13] = mk(0, 0, 0, 0, 0, 32'h3,   1, 1, 32'h1, 0, 32'h0, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 32'h3,   1, 1, 32'h1, 0, 32'h0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'h3,   1, 1, 32'h1, 0, 32'h0, 1);
        vecs[16] = mk(0, 0, 0, 1, 0, 32'h3,   0, 0, 32'h0, 0, 32'h0, 0);
        // spurious IDs 0 and 5
        vecs[17] = mk(0, 1, 1, 1, 0, 32'h0,   1, 0, 32'h0, 0, 32'h0, 1);
        vecs[18] = mk(0, 1, 1, 1, 0, 32'h0,   0, 0, 32'h0, 0, 32'h0, 0);
        vecs[19] = mk(0, 0, 1, 1, 0, 32'h5,   0, 0, 32'h0, 0, 32'h0, 0);
        vecs[20] = mk(0, 1, 1, 1, 0, 32'h5,   1, 0, 32'h0, 0, 32'h0, 1);
        vecs[21] = mk(0, 0, 1, 1, 0, 32'h5,   0, 0, 32'h0, 0, 32'h0, 0);

        reset = 1'b1; EIP = 1'b0; globalEnable = 1'b0; irqDone = 1'b0;
        bus.memReady = 1'b0; bus.memReadData = 32'h0;
        #1;

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; EIP = vecs[i].eip; globalEnable = vecs[i].ge;
            bus.memReady = vecs[i].rdy; irqDone = vecs[i].done;
            bus.memReadData = vecs[i].rd;
            cycle();
            check_all(i, vecs[i].req, vecs[i].wr, vecs[i].wdata,
                      vecs[i].valid, vecs[i].id, vecs[i].bsy);
            $display("vec %0d: req=%b wr=%b addr=%h wdata=%h valid=%b id=%h busy=%b",
                     i, bus.memRequest, bus.memWrite, bus.memAddress,
                     bus.memWriteData, irqValid, irqId, busy);
        end

`ifdef PLIC_CLAIM_STATS_EN
        chk("claimCount", 100, {16'd0, claimCount}, 32'd4);
        chk("spuriousCount", 100, {16'd0, spuriousCount}, 32'd2);
`endif

        // Gating: EIP high with interrupts disabled never requests
        EIP = 1'b1; globalEnable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("gated_req", 200 + i, {31'd0, bus.memRequest}, 32'd0);
        end
        $display("gating: 10 cycles EIP=1 globalEnable=0 req=%b", bus.memRequest);

        // Back-to-back: EIP held, immediate grant, irqDone already high
        globalEnable = 1'b1; bus.memReady = 1'b1; bus.memReadData = 32'h1; irqDone = 1'b1;
        cycle(); check_all(300, 1, 0, 32'h0, 0, 32'h0, 1);
        cycle(); check_all(301, 0, 0, 32'h0, 1, 32'h1, 1);
        cycle(); check_all(302, 1, 1, 32'h1, 0, 32'h0, 1);
        cycle(); check_all(303, 0, 0, 32'h0, 0, 32'h0, 0);
        irqDone = 1'b0;
        cycle(); check_all(304, 1, 0, 32'h0, 0, 32'h0, 1);
        cycle(); check_all(305, 0, 0, 32'h0, 1, 32'h1, 1);
        $display("back-to-back: one idle cycle then reclaim, irqId=%h", irqId);

        // Reset during DISPATCH abandons the sequence with no complete write
        reset = 1'b1; irqDone = 1'b1;
        cycle(); check_all(400, 0, 0, 32'h0, 0, 32'h0, 0);
`ifdef PLIC_CLAIM_STATS_EN
        chk("claimCount_rst", 401, {16'd0, claimCount}, 32'd0);
`endif
        reset = 1'b0; EIP = 1'b0; irqDone = 1'b0;
        writes = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (bus.memWrite) writes++;
        end
        chk("no_complete_after_reset", 402, writes, 32'd0);
        chk("idle_after_reset", 403, {31'd0, busy}, 32'd0);
        $display("reset in dispatch: writes=%0d busy=%b", writes, busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
